jk_excite_driver: RTL and testbench

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

---
 rtl/jk_excite_driver.sv | 136 +++++++++++++
 tb/tb_jk_excite_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// Drives the J/K inputs of an external JK flop to reach a requested value,
// then watches q/q_bar feedback for success, inconsistency or timeout.
module jk_excite_driver #(
    parameter int TIMEOUT    = 4,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_q,
    output logic       req_ready,
    input  logic       q_fb,
    input  logic       q_bar_fb,
    output logic       j,
    output logic       k,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       target_q, target_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic fb_match;
    logic fb_bad;
    logic timeout_hit;

    assign fb_match    = (q_fb == target_q) && (q_bar_fb == ~target_q);
    assign fb_bad      = (q_fb == q_bar_fb);
    assign timeout_hit = (wait_cnt_q == LAST_WAIT);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            target_q   <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            target_q   <= target_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        target_d   = target_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_q;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (fb_match || fb_bad || timeout_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        j_d       = 1'b0;
        k_d       = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (USE_TOGGLE) begin
                        j_d = (q_fb != req_q);
                        k_d = (q_fb != req_q);
                    end else begin
                        j_d = req_q;
                        k_d = ~req_q;
                    end
                end
            end
            ST_WAIT: begin
                // A match wins over both the inconsistency and timeout checks.
                if (fb_match) begin
                    done_d = 1'b1;
                end else if (fb_bad || timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver: one set/reset-mode and one toggle-mode
// driver, each closing the loop through a behavioural JK flop.
module tb_jk_excite_driver;

    logic       clk = 1'b0;
    logic       reset;

    // Set/reset-mode instance with overridable feedback.
    logic       req_valid0, req_q0, req_ready0, j0, k0, done0, err0;
    logic [7:0] err_cnt0;
    logic       fq0, q_fb0, q_bar_fb0;
    int         fb_mode0;   // 0 = real flop, 1 = stuck q=0/q_bar=1, 2 = both high

    // Toggle-mode instance with an ideal flop.
    logic       req_valid1, req_q1, req_ready1, j1, k1, done1, err1;
    logic [7:0] err_cnt1;
    logic       fq1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign q_fb0     = (fb_mode0 == 0) ? fq0  : (fb_mode0 == 1) ? 1'b0 : 1'b1;
    assign q_bar_fb0 = (fb_mode0 == 0) ? ~fq0 : 1'b1;

    always @(posedge clk) begin
        if (reset) fq0 <= 1'b0;
        else case ({j0, k0})
            2'b10: fq0 <= 1'b1;
            2'b01: fq0 <= 1'b0;
            2'b11: fq0 <= ~fq0;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (reset) fq1 <= 1'b0;
        else case ({j1, k1})
            2'b10: fq1 <= 1'b1;
            2'b01: fq1 <= 1'b0;
            2'b11: fq1 <= ~fq1;
            default: ;
        endcase
    end

    jk_excite_driver #(.TIMEOUT(4), .USE_TOGGLE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_q(req_q0),
        .req_ready(req_ready0), .q_fb(q_fb0), .q_bar_fb(q_bar_fb0),
        .j(j0), .k(k0), .done(done0), .err(err0), .err_cnt(err_cnt0)
    );

    jk_excite_driver #(.TIMEOUT(4), .USE_TOGGLE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_q(req_q1),
        .req_ready(req_ready1), .q_fb(fq1), .q_bar_fb(~fq1),
        .j(j1), .k(k1), .done(done1), .err(err1), .err_cnt(err_cnt1)
    );

    // Advance one rising edge; outputs are then observed and inputs changed at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid0 = 1'b1; req_q0 = 1'b1; req_valid1 = 1'b1; req_q1 = 1'b1;
        step();
        n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", req_ready0); end
        n_checks++; if ({j0, k0} !== 2'b00) begin n_fail++; $display("FAIL reset_jk0: got %b want 00", {j0, k0}); end
        n_checks++; if ({done0, err0} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err0: got %b want 00", {done0, err0}); end
        n_checks++; if (err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt0: got %0d want 0", err_cnt0); end
        n_checks++; if ({req_ready1, j1, k1} !== 3'b100) begin n_fail++; $display("FAIL reset_dut1: got %b want 100", {req_ready1, j1, k1}); end
        reset = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
        step();
        n_checks++; if ({j0, k0, req_ready0} !== 3'b001) begin n_fail++; $display("FAIL reset_release_idle0: got %b want 001", {j0, k0, req_ready0}); end
    endtask

    task automatic test_set_reset_mode();
        req_valid0 = 1'b1; req_q0 = 1'b1;
        step();                                   // E0
        req_valid0 = 1'b0;
        n_checks++; if ({j0, k0} !== 2'b10) begin n_fail++; $display("FAIL sr_e0_jk: got %b want 10", {j0, k0}); end
        n_checks++; if (req_ready0 !== 1'b0) begin n_fail++; $display("FAIL sr_e0_ready: got %b want 0", req_ready0); end
        step();                                   // E1
        n_checks++; if ({j0, k0} !== 2'b00) begin n_fail++; $display("FAIL sr_e1_jk: got %b want 00", {j0, k0}); end
        n_checks++; if (fq0 !== 1'b1) begin n_fail++; $display("FAIL sr_e1_q: got %b want 1", fq0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL sr_e1_done: got %b want 0", done0); end
        step();                                   // E2
        n_checks++; if ({done0, err0, req_ready0} !== 3'b101) begin n_fail++; $display("FAIL sr_e2_done_err_ready: got %b want 101", {done0, err0, req_ready0}); end
        step();
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL sr_done_width: got %b want 0", done0); end
    endtask

    task automatic test_toggle_mode();
        logic rq  [3] = '{1'b1, 1'b0, 1'b0};
        logic ejk [3] = '{1'b1, 1'b1, 1'b0};
        logic eq  [3] = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            req_valid1 = 1'b1; req_q1 = rq[t];
            step();                               // E0
            req_valid1 = 1'b0;
            n_checks++; if ({j1, k1} !== {ejk[t], ejk[t]}) begin n_fail++; $display("FAIL tg%0d_e0_jk: got %b want %b", t, {j1, k1}, {ejk[t], ejk[t]}); end
            step();                               // E1
            n_checks++; if ({j1, k1} !== 2'b00) begin n_fail++; $display("FAIL tg%0d_e1_jk: got %b want 00", t, {j1, k1}); end
            n_checks++; if (fq1 !== eq[t]) begin n_fail++; $display("FAIL tg%0d_q: got %b want %b", t, fq1, eq[t]); end
            step();                               // E2
            n_checks++; if ({done1, err1, req_ready1} !== 3'b101) begin n_fail++; $display("FAIL tg%0d_done: got %b want 101", t, {done1, err1, req_ready1}); end
            step();
        end
    endtask

    task automatic test_timeout();
        fb_mode0 = 1;
        req_valid0 = 1'b1; req_q0 = 1'b1;
        step();                                   // E0
        req_valid0 = 1'b0;
        n_checks++; if ({j0, k0} !== 2'b10) begin n_fail++; $display("FAIL to_e0_jk: got %b want 10", {j0, k0}); end
        for (int e = 1; e <= 5; e++) begin
            step();
            n_checks++; if (err0 !== (e == 5)) begin n_fail++; $display("FAIL to_err_e%0d: got %b want %b", e, err0, (e == 5)); end
            n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL to_done_e%0d: got %b want 0", e, done0); end
        end
        n_checks++; if (err_cnt0 !== 8'd1) begin n_fail++; $display("FAIL to_err_cnt: got %0d want 1", err_cnt0); end
        n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b want 1", req_ready0); end
        step();
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL to_err_width: got %b want 0", err0); end
        fb_mode0 = 0;
    endtask

    task automatic test_inconsistent();
        fb_mode0 = 2;
        req_valid0 = 1'b1; req_q0 = 1'b0;
        step();                                   // E0
        req_valid0 = 1'b0;
        n_checks++; if ({j0, k0} !== 2'b01) begin n_fail++; $display("FAIL inc_e0_jk: got %b want 01", {j0, k0}); end
        step();                                   // E1
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL inc_e1_err: got %b want 0", err0); end
        step();                                   // E2, first WAIT edge
        n_checks++; if ({done0, err0, req_ready0} !== 3'b011) begin n_fail++; $display("FAIL inc_e2: got %b want 011", {done0, err0, req_ready0}); end
        n_checks++; if (err_cnt0 !== 8'd2) begin n_fail++; $display("FAIL inc_err_cnt: got %0d want 2", err_cnt0); end
        step();
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL inc_err_width: got %b want 0", err0); end
        fb_mode0 = 0;
    endtask

    task automatic test_back_to_back();
        req_valid0 = 1'b1; req_q0 = 1'b1;         // held high across the whole first operation
        step();                                   // E0
        n_checks++; if ({j0, k0} !== 2'b10) begin n_fail++; $display("FAIL b2b_e0_jk: got %b want 10", {j0, k0}); end
        step();                                   // E1: held request must not be re-accepted
        n_checks++; if ({j0, k0, req_ready0} !== 3'b000) begin n_fail++; $display("FAIL b2b_e1: got %b want 000", {j0, k0, req_ready0}); end
        step();                                   // E2
        n_checks++; if ({done0, req_ready0, fq0} !== 3'b111) begin n_fail++; $display("FAIL b2b_e2: got %b want 111", {done0, req_ready0, fq0}); end
        req_q0 = 1'b0;
        step();                                   // E3: second request accepted
        req_valid0 = 1'b0;
        n_checks++; if ({j0, k0, done0, req_ready0} !== 4'b0100) begin n_fail++; $display("FAIL b2b_e3: got %b want 0100", {j0, k0, done0, req_ready0}); end
        step();                                   // E4
        n_checks++; if (fq0 !== 1'b0) begin n_fail++; $display("FAIL b2b_q: got %b want 0", fq0); end
        step();                                   // E5
        n_checks++; if ({done0, err0} !== 2'b10) begin n_fail++; $display("FAIL b2b_e5_done: got %b want 10", {done0, err0}); end
        step();
    endtask

    task automatic test_reset_in_wait();
        fb_mode0 = 1;
        req_valid0 = 1'b1; req_q0 = 1'b1;
        step();                                   // E0
        req_valid0 = 1'b0;
        step();                                   // E1
        step();                                   // E2, still waiting
        n_checks++; if (req_ready0 !== 1'b0) begin n_fail++; $display("FAIL rw_busy: got %b want 0", req_ready0); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if ({j0, k0, done0, err0} !== 4'b0000) begin n_fail++; $display("FAIL rw_outputs: got %b want 0000", {j0, k0, done0, err0}); end
        n_checks++; if (err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL rw_err_cnt: got %0d want 0", err_cnt0); end
        n_checks++; if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", req_ready0); end
        for (int e = 0; e < 5; e++) begin
            step();
            n_checks++; if ({done0, err0} !== 2'b00) begin n_fail++; $display("FAIL rw_no_pulse_%0d: got %b want 00", e, {done0, err0}); end
        end
    endtask

    task automatic test_saturation();
        fb_mode0 = 1;
        for (int i = 0; i < 256; i++) begin
            req_valid0 = 1'b1; req_q0 = 1'b1;
            step();                               // E0
            req_valid0 = 1'b0;
            repeat (5) step();                    // through E5
            n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL sat_err_pulse_%0d: got %b want 1", i, err0); end
            if (i == 253) begin
                n_checks++; if (err_cnt0 !== 8'd254) begin n_fail++; $display("FAIL sat_cnt_254: got %0d want 254", err_cnt0); end
            end
            if (i >= 254) begin
                n_checks++; if (err_cnt0 !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d want 255", i, err_cnt0); end
            end
        end
        step();
        n_checks++; if ({err0, err_cnt0} !== {1'b0, 8'd255}) begin n_fail++; $display("FAIL sat_final: got err=%b cnt=%0d want err=0 cnt=255", err0, err_cnt0); end
        fb_mode0 = 0;
    endtask

    initial begin
        reset = 1'b1; fb_mode0 = 0;
        req_valid0 = 1'b0; req_q0 = 1'b0; req_valid1 = 1'b0; req_q1 = 1'b0;
        step();
        test_reset();
        test_set_reset_mode();
        test_toggle_mode();
        test_timeout();
        test_inconsistent();
        test_back_to_back();
        test_reset_in_wait();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
